// File: rtl/ha_df.sv
// One-bit half adder: combinational {cout,sum} = a + b, plus a registered copy
// of the same result for pipelined users.
module ha_df (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic cout,
    output logic sum,
    output logic cout_q,
    output logic sum_q
);

    logic cout_d;
    logic sum_d;

    assign cout   = a & b;
    assign sum    = a ^ b;
    assign cout_d = cout;
    assign sum_d  = sum;

    // Registered result: one cycle behind the combinational path, and forced low while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cout_q <= 1'b0;
            sum_q  <= 1'b0;
        end else begin
            cout_q <= cout_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: tb/tb_ha_df.sv
// Self-checking bench for ha_df: directed scenarios plus randomized traffic
// checked against an arithmetic reference (a + b).
module tb_ha_df;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic reset  = 1'b0;
    logic a      = 1'b0;
    logic b      = 1'b0;
    logic cout;
    logic sum;
    logic cout_q;
    logic sum_q;

    int errors = 0;
    int checks = 0;

    ha_df dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .cout   (cout),
        .sum    (sum),
        .cout_q (cout_q),
        .sum_q  (sum_q)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [1:0] ref_add(input logic x, input logic y);
        logic [1:0] r;
        r = 2'(x) + 2'(y);
        return r;
    endfunction

    task automatic test_reset();
        #1;
        reset = 1'b1;
        #2;
        checks++;
        if ({cout_q, sum_q} !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got %b want 00", {cout_q, sum_q});
        end
    endtask

    task automatic test_comb();
        logic [1:0] exp_tab [4];
        logic [1:0] ab;
        exp_tab[0] = 2'b00;
        exp_tab[1] = 2'b01;
        exp_tab[2] = 2'b01;
        exp_tab[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a  = ab[1];
            b  = ab[0];
            #1;
            checks++;
            if ({cout, sum} !== exp_tab[i]) begin
                errors++;
                $display("FAIL comb_ab%b: got %b want %b", ab, {cout, sum}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_independence();
        clk_en = 1'b0;
        reset  = 1'b1;
        a = 1'b1;
        b = 1'b1;
        #1;
        checks++;
        if ({cout, sum, cout_q, sum_q} !== 4'b1000) begin
            errors++;
            $display("FAIL comb_indep: got cout,sum,cout_q,sum_q=%b want 1000",
                     {cout, sum, cout_q, sum_q});
        end
        #20;
        checks++;
        if ({cout, sum, cout_q, sum_q} !== 4'b1000) begin
            errors++;
            $display("FAIL comb_indep_hold: got %b want 1000", {cout, sum, cout_q, sum_q});
        end
        clk_en = 1'b1;
    endtask

    task automatic test_latency();
        @(negedge clk);
        reset = 1'b0;
        a = 1'b1;
        b = 1'b1;
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b00) begin
            errors++;
            $display("FAIL latency_pre_edge: got %b want 00", {cout_q, sum_q});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b10) begin
            errors++;
            $display("FAIL latency_11: got %b want 10", {cout_q, sum_q});
        end
        @(negedge clk);
        a = 1'b0;
        b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b01) begin
            errors++;
            $display("FAIL latency_01: got %b want 01", {cout_q, sum_q});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cout_q !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: cout_q got %b want 1", cout_q);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got %b want 00", {cout_q, sum_q});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: got %b want 00", {cout_q, sum_q});
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        a = 1'b1;
        b = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b00) begin
            errors++;
            $display("FAIL release_pre_edge: got %b want 00", {cout_q, sum_q});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout_q, sum_q} !== 2'b01) begin
            errors++;
            $display("FAIL release_capture: got %b want 01", {cout_q, sum_q});
        end
    endtask

    task automatic test_random();
        logic [1:0] prev_res;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a = 1'($urandom);
            b = 1'($urandom);
            #1;
            prev_res = ref_add(a, b);
            checks++;
            if ({cout, sum} !== prev_res) begin
                errors++;
                $display("FAIL rand_comb[%0d]: a=%b b=%b got %b want %b",
                         i, a, b, {cout, sum}, prev_res);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({cout_q, sum_q} !== prev_res) begin
                errors++;
                $display("FAIL rand_reg[%0d]: got %b want %b", i, {cout_q, sum_q}, prev_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_independence();
        test_latency();
        test_async_reset();
        test_release();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
